// File: rtl/sbus_tx_pkg.sv
// Shared SBUS constants, FSM state types and parity helper for the SBUS TX path.
// Optional build macro SBUS_TX_INVERT_EN (used by sbus_tx) selects true inverted SBUS line polarity.
package sbus_tx_pkg;

  localparam logic [7:0] SBUS_HEADER        = 8'h0F;
  localparam logic [7:0] SBUS_FOOTER        = 8'h00;
  localparam int         SBUS_NUM_CH        = 16;
  localparam int         SBUS_CH_BITS       = 11;
  localparam int         SBUS_FRAME_BYTES   = 25;
  localparam int         SBUS_BITS_PER_BYTE = 12;
  localparam int         SBUS_BAUD          = 100_000;

  localparam int SBUS_CH_W   = SBUS_NUM_CH * SBUS_CH_BITS;
  localparam int SBUS_SNAP_W = SBUS_FRAME_BYTES * 8;

  typedef enum logic [2:0] {
    BT_IDLE,
    BT_START,
    BT_DATA,
    BT_PARITY,
    BT_STOP1,
    BT_STOP2
  } byte_state_t;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_FIN
  } frame_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sbus_tx_byte.sv
// 8E2 byte serializer: start, 8 data bits LSB first, even parity, two stop bits,
// each held BIT_CYCLES clocks. A load in the last cycle of STOP2 chains the next byte with no gap.
module sbus_byte_tx
  import sbus_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       tx_bit
);

  localparam int             CW      = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BIT_CYCLES - 1);

  byte_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par;
  logic          bit_end;
  logic          accept;

  assign bit_end = (cnt == '0);
  assign accept  = load && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BT_IDLE;
    else     state <= state_nxt;
  end

  // Down-counter reloads at 0, so each bit lasts exactly BIT_CYCLES clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_MAX;
      bit_idx <= '0;
      shreg   <= data;
      par     <= even_parity(data);
    end else if (state != BT_IDLE) begin
      cnt <= bit_end ? CNT_MAX : cnt - 1'b1;
      if (state == BT_DATA && bit_end) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BT_IDLE:   if (load) state_nxt = BT_START;
      BT_START:  if (bit_end) state_nxt = BT_DATA;
      BT_DATA:   if (bit_end && bit_idx == 3'd7) state_nxt = BT_PARITY;
      BT_PARITY: if (bit_end) state_nxt = BT_STOP1;
      BT_STOP1:  if (bit_end) state_nxt = BT_STOP2;
      BT_STOP2:  if (bit_end) state_nxt = load ? BT_START : BT_IDLE;
      default:   state_nxt = BT_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == BT_IDLE) || (state == BT_STOP2 && bit_end);
    done   = (state == BT_STOP2) && bit_end;
    tx_bit = 1'b1;
    unique case (state)
      BT_IDLE:   tx_bit = 1'b1;
      BT_START:  tx_bit = 1'b0;
      BT_DATA:   tx_bit = shreg[bit_idx];
      BT_PARITY: tx_bit = par;
      BT_STOP1:  tx_bit = 1'b1;
      BT_STOP2:  tx_bit = 1'b1;
      default:   tx_bit = 1'b1;
    endcase
  end

endmodule

// File: rtl/sbus_tx.sv
// SBUS frame transmitter: snapshots 16x11-bit channels + flags and sends a 25-byte 8E2 frame.
// Define SBUS_TX_INVERT_EN for true (inverted) SBUS line polarity; default is plain UART levels.
module sbus_tx
  import sbus_tx_pkg::*;
#(
  parameter int BASE_FREQ = 100_000_000,
  parameter int BAUD      = SBUS_BAUD
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [SBUS_CH_W-1:0] CHANNELS,
  input  logic [3:0]           FLAGS,
  input  logic                 SEND,
  output logic                 READY,
  output logic                 DONE,
  output logic                 TX_OUT
);

  localparam int         BIT_CYCLES = BASE_FREQ / BAUD;
  localparam logic [4:0] LAST_BYTE  = 5'(SBUS_FRAME_BYTES - 1);

  if (BIT_CYCLES < 4) begin : g_bad_baud
    $error("sbus_tx: BASE_FREQ/BAUD must be at least 4");
  end

  frame_state_t           state, state_nxt;
  logic [SBUS_SNAP_W-1:0] snap;
  logic [4:0]             byte_idx;
  logic [4:0]             byte_idx_nxt;
  logic                   accept;
  logic                   more_bytes;
  logic                   byte_load;
  logic [7:0]             byte_data;
  logic                   byte_ready;
  logic                   byte_done;
  logic                   tx_bit;

  assign accept       = SEND && READY;
  assign more_bytes   = (state == FR_SEND) && byte_done && (byte_idx != LAST_BYTE);
  assign byte_idx_nxt = (byte_idx == LAST_BYTE) ? byte_idx : byte_idx + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FR_IDLE;
    else       state <= state_nxt;
  end

  // Whole frame is captured at accept so byte k is simply snap[8k +: 8].
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      snap     <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      snap     <= {SBUS_FOOTER, {4'b0000, FLAGS}, CHANNELS, SBUS_HEADER};
      byte_idx <= '0;
    end else if (more_bytes) begin
      byte_idx <= byte_idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FR_IDLE: if (accept) state_nxt = FR_SEND;
      FR_SEND: if (byte_done && byte_idx == LAST_BYTE) state_nxt = FR_FIN;
      FR_FIN:  state_nxt = accept ? FR_SEND : FR_IDLE;
      default: state_nxt = FR_IDLE;
    endcase
  end

  // FIN also counts as ready so a held SEND restarts with no idle gap.
  always_comb begin
    READY     = ((state == FR_IDLE) || (state == FR_FIN)) && byte_ready;
    DONE      = (state == FR_FIN);
    byte_load = accept || more_bytes;
    byte_data = accept ? SBUS_HEADER : snap[{byte_idx_nxt, 3'b000} +: 8];
  end

  sbus_byte_tx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_byte_tx (
    .clk    (CLK),
    .rst    (RESET),
    .load   (byte_load),
    .data   (byte_data),
    .ready  (byte_ready),
    .done   (byte_done),
    .tx_bit (tx_bit)
  );

`ifdef SBUS_TX_INVERT_EN
  assign TX_OUT = ~tx_bit;
`else
  assign TX_OUT = tx_bit;
`endif

endmodule
